// File: rtl/mux_rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbitrating mux.
package mux_rr_arb_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned NCH_DEF   = 4;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_rr_arb_rr_arbiter.sv
// Combinational rotate-priority arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned SELW = 2
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  grant,
  output logic [SELW-1:0] idx,
  output logic            any
);

  logic [2*NCH-1:0] rot;

  assign rot = {req, req} >> ptr;

  always_comb begin
    int unsigned sum;
    sum   = 0;
    idx   = '0;
    any   = 1'b0;
    grant = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        sum = 32'(ptr) + k;
        if (sum >= NCH) sum = sum - NCH;
        idx = SELW'(sum);
      end
    end
    for (int unsigned j = 0; j < NCH; j++) begin
      grant[j] = any && (idx == SELW'(j));
    end
  end

endmodule

// File: rtl/mux_rr_arb.sv
// N-channel valid/ready mux with round-robin or fixed select, optional packet lock,
// and a single registered output stage.
module mux_rr_arb
  import mux_rr_arb_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned NCH   = NCH_DEF,
  parameter int unsigned SELW  = clog2(NCH),
  parameter bit          PKT   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_last,
  output logic [NCH-1:0]       in_ready,
  input  logic                 fix_en,
  input  logic [SELW-1:0]      fix_sel,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_last,
  input  logic                 out_ready
);

  localparam int unsigned IW = clog2(NCH * WIDTH);

  state_e          state;
  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] lock_ch;
  logic [NCH-1:0]  req;
  logic [NCH-1:0]  grant;
  logic [SELW-1:0] idx;
  logic            any;
  logic            load_en;
  logic            xfer;
  logic            beat_last;
  logic [SELW-1:0] next_ptr;
  logic [IW-1:0]   base;

  // Mask requests down to the locked channel or the fixed channel before arbitration.
  always_comb begin
    req = '0;
    if (state == ST_LOCK) begin
      req[lock_ch] = in_valid[lock_ch];
    end else if (fix_en) begin
      if (32'(fix_sel) < NCH) req[fix_sel] = in_valid[fix_sel];
    end else begin
      req = in_valid;
    end
  end

  rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (idx),
    .any   (any)
  );

  assign load_en   = !out_valid || out_ready;
  assign in_ready  = grant & {NCH{load_en & reset_n}};
  assign xfer      = any && load_en;
  assign beat_last = PKT ? in_last[idx] : 1'b0;
  assign next_ptr  = (idx == SELW'(NCH - 1)) ? '0 : idx + SELW'(1);
  assign base      = IW'(idx) * IW'(WIDTH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_ARB;
      rr_ptr    <= '0;
      lock_ch   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data[base +: WIDTH];
        out_ch    <= idx;
        out_last  <= beat_last;
        // A packet ending in lock always advances the pointer, even under fix_en.
        if (state == ST_LOCK || !fix_en) rr_ptr <= next_ptr;
        if (PKT) begin
          if (state == ST_ARB && !beat_last) begin
            state   <= ST_LOCK;
            lock_ch <= idx;
          end else if (state == ST_LOCK && beat_last) begin
            state <= ST_ARB;
          end
        end
      end else if (load_en) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
